div4_restoring_seq: RTL and testbench



---
 rtl/div4_restoring_seq.sv | 110 +++++++++++
 tb/tb_div4_restoring_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div4_restoring_seq.sv
// Sequential 4-bit unsigned restoring divider wrapped around an external 4-bit
// ripple subtractor; one quotient bit per clock under a start/done handshake.
module div4_restoring_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] sub_a,
    output logic [3:0] sub_b,
    output logic       sub_c0,
    input  logic [3:0] sub_s,
    input  logic       sub_cout,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] q_r, r_r, d_r;
    logic [1:0] cnt;
    logic       start_ok;
    logic       accept;
    logic [3:0] q_step, r_step;

    assign sub_c0 = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        sub_a     = 4'd0;
        sub_b     = 4'd0;
        accept    = 1'b0;
        q_step    = q_r;
        r_step    = r_r;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, FIN: begin
                done      = (state == FIN);
                start_ok  = start;
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = (divisor == 4'd0) ? FIN : CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                sub_a  = {r_r[2:0], q_r[3]};
                sub_b  = d_r;
                // R[3] set means the shifted remainder is >= 16, always above D
                accept = r_r[3] | sub_cout;
                q_step = {q_r[2:0], accept};
                r_step = accept ? sub_s : sub_a;
                if (cnt == 2'd3) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= 4'd0;
            r_r         <= 4'd0;
            d_r         <= 4'd0;
            cnt         <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else if (start_ok) begin
            q_r <= dividend;
            d_r <= divisor;
            r_r <= 4'd0;
            cnt <= 2'd0;
            if (divisor == 4'd0) begin
                quotient    <= 4'hF;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            q_r <= q_step;
            r_r <= r_step;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                quotient    <= q_step;
                remainder   <= r_step;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div4_restoring_seq.sv
// Scoreboard bench for div4_restoring_seq with a behavioural subtractor and a
// plain-arithmetic division reference model.
module tb_div4_restoring_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = 4'd0;
    logic [3:0] divisor = 4'd0;
    logic [3:0] sub_a, sub_b, sub_s;
    logic       sub_c0, sub_cout;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    div4_restoring_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .sub_a(sub_a), .sub_b(sub_b), .sub_c0(sub_c0),
        .sub_s(sub_s), .sub_cout(sub_cout),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    // External ripple subtractor: a + ~b + c0
    assign sub_s    = sub_a - sub_b - {3'd0, ~sub_c0};
    assign sub_cout = ({1'b0, sub_a} + {1'b0, ~sub_b} + {4'd0, sub_c0}) > 5'd15;

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int dbz;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected result whenever done is seen
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_latency", cyc, e.due);
                    chk("busy_cycles", busy_run, e.dbz ? 0 : 4);
                end
                busy_run = 0;
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("done_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge with the DUT able to accept; returns just after E0
    task automatic start_div(input int a, input int b);
        exp_t e;
        dividend = a[3:0];
        divisor  = b[3:0];
        start    = 1'b1;
        if (b == 0) begin
            e.q = 15; e.r = a; e.dbz = 1; e.due = cyc + 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 0; e.due = cyc + 5;
        end
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", 1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_quotient"}, quotient, 0);
        chk({tag, "_remainder"}, remainder, 0);
        chk({tag, "_dbz"}, div_by_zero, 0);
        chk({tag, "_sub_a"}, sub_a, 0);
        chk({tag, "_sub_b"}, sub_b, 0);
        chk({tag, "_sub_c0"}, sub_c0, 1);
    endtask

    int dir_a[6] = '{15, 7, 15, 15, 9, 6};
    int dir_b[6] = '{1, 9, 15, 2, 0, 3};
    int port_a[4] = '{1, 3, 0, 1};

    initial begin
        #3 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 13/3 with subtractor-port trace
        start_div(13, 3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("calc_busy", busy, 1);
            chk("sub_a", sub_a, port_a[i]);
            chk("sub_b", sub_b, 3);
            chk("sub_c0", sub_c0, 1);
            @(negedge clk);
        end
        chk("port_done", done, 1);
        @(negedge clk);
        chk("idle_sub_a", sub_a, 0);

        // Boundary values and divide-by-zero followed by a normal divide
        for (int i = 0; i < 6; i++) begin
            start_div(dir_a[i], dir_b[i]);
            wait_ready();
        end
        repeat (3) @(negedge clk);

        // Start while busy is ignored; start in the done cycle is accepted
        start_div(13, 3);
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready();
        chk("b2b_done_cycle", done, 1);
        start_div(15, 1);
        wait_ready();
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of 14/7
        start_div(14, 7);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 chk_all_zero("abort");
        repeat (3) @(negedge clk);
        chk_all_zero("abort_hold");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done, 0);
        start_div(14, 7);
        wait_ready();

        // Exhaustive non-zero sweep with random idle gaps
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_div(a, b);
                wait_ready();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Random pairs including zero divisors
        for (int i = 0; i < 60; i++) begin
            start_div($urandom_range(0, 15), $urandom_range(0, 15));
            wait_ready();
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
